// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: small program store plus program counter that presents
// one {opcode, opr1, opr2} word per decoder round of SLOT_CYCLES clocks.
module instr_fetch_unit #(
  parameter int unsigned AW          = 4,
  parameter int unsigned SLOT_CYCLES = 4,
  parameter logic [3:0]  HALT_OP     = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          restart,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  output logic [3:0]    opcode,
  output logic [3:0]    opr1,
  output logic [7:0]    opr2,
  output logic [AW-1:0] pc,
  output logic          instr_valid,
  output logic          halted
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_HALT
  } state_t;

  state_t        state;
  logic [CW-1:0] slot_cnt;
  logic [15:0]   rom [DEPTH];

  logic          slot_end;
  logic          do_fetch;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] fetch_addr;
  logic [15:0]   fetch_word;

  // In HOLD the next word is fetched at the slot boundary, in IDLE the word at pc.
  assign slot_end   = (state == S_HOLD) && (slot_cnt == SLOT_LAST);
  assign pc_inc     = pc + AW'(1);
  assign fetch_addr = (state == S_HOLD) ? pc_inc : pc;
  assign fetch_word = rom[fetch_addr];
  assign do_fetch   = run && (((state == S_IDLE) && !restart) || slot_end);

  // Program store is not reset; writes are locked out while an instruction is presented.
  always_ff @(posedge clk) begin
    if (prog_we && (state != S_HOLD)) begin
      rom[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      slot_cnt    <= '0;
      opcode      <= '0;
      opr1        <= '0;
      opr2        <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (do_fetch) begin
      opcode   <= fetch_word[15:12];
      opr1     <= fetch_word[11:8];
      opr2     <= fetch_word[7:0];
      slot_cnt <= '0;
      if (state == S_HOLD) begin
        pc <= pc_inc;
      end
      if (fetch_word[15:12] != HALT_OP) begin
        instr_valid <= 1'b1;
        state       <= S_HOLD;
      end else begin
        instr_valid <= 1'b0;
        halted      <= 1'b1;
        state       <= S_HALT;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (restart) begin
            pc <= '0;
          end
        end
        S_HOLD: begin
          if (slot_end) begin
            pc          <= pc_inc;
            slot_cnt    <= '0;
            instr_valid <= 1'b0;
            state       <= S_IDLE;
          end else begin
            slot_cnt <= slot_cnt + CW'(1);
          end
        end
        S_HALT: begin
          if (restart) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
